// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads the zero-latency instruction memory every
// cycle and queues {pc, inst} pairs in a small FIFO drained by decode via valid/ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_inst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [31:0]              if_inst,
  output logic [31:0]              if_pc,
  output logic [$clog2(DEPTH):0]   if_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   buf_pc_q [DEPTH];
  logic [31:0]   buf_pc_d [DEPTH];
  logic [31:0]   buf_inst_q [DEPTH];
  logic [31:0]   buf_inst_d [DEPTH];
  logic          push_s;
  logic          pop_s;
  logic          redirect_lsb_unused_s;

  // Fetch addresses are word aligned, so the low redirect bits are dropped.
  assign redirect_lsb_unused_s = ^redirect_pc[1:0];

  assign imem_addr = pc_q;
  assign if_valid  = (count_q != {CW{1'b0}});
  assign if_inst   = buf_inst_q[rd_ptr_q];
  assign if_pc     = buf_pc_q[rd_ptr_q];
  assign if_count  = count_q;

  // Next-state logic for PC, pointers, occupancy and buffer storage.
  always_comb begin
    pop_s      = if_valid && if_ready && !redirect_valid;
    push_s     = !redirect_valid && ((count_q < CNT_FULL) || pop_s);
    pc_d       = pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;

    if (redirect_valid) begin
      // Flush wins over everything; the head shown this cycle is not consumed.
      pc_d     = {redirect_pc[31:2], 2'b00};
      count_d  = {CW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
    end else begin
      if (push_s) begin
        buf_pc_d[wr_ptr_q]   = pc_q;
        buf_inst_d[wr_ptr_q] = imem_inst;
        wr_ptr_d             = wr_ptr_q + PTR_ONE;
        pc_d                 = pc_q + 32'd4;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset that also clears the buffer storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      count_q  <= {CW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]   <= 32'h0000_0000;
        buf_inst_q[i] <= 32'h0000_0000;
      end
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural zero-latency instruction memory.
module tb_inst_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [1:0]  if_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc   [9];
  logic [31:0] exp_inst [9];

  inst_fetch #(.RESET_PC(32'h0000_0004), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
    .if_pc(if_pc), .if_count(if_count)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h04:  return 32'h0010_0293;
      32'h08:  return 32'h0030_0313;
      32'h0C:  return 32'h0062_B223;
      32'h10:  return 32'h0062_E3B3;
      32'h14:  return 32'h0053_B123;
      32'h18:  return 32'h0042_B303;
      32'h1C:  return 32'h0062_8263;
      32'h20:  return 32'h0062_82B3;
      32'h24:  return 32'h4053_83B3;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign imem_inst = mem_f(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_pc   = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24};
    exp_inst = '{32'h0010_0293, 32'h0030_0313, 32'h0062_B223, 32'h0062_E3B3, 32'h0053_B123,
                 32'h0042_B303, 32'h0062_8263, 32'h0062_82B3, 32'h4053_83B3};

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
    step(); step();
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_inst",  if_inst, 32'h0);
    check("rst_pc",    if_pc, 32'h0);
    check("rst_addr",  imem_addr, 32'h4);
    check("rst_count", {30'd0, if_count}, 32'd0);

    // Streaming with decode always ready.
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      check("stream_valid", {31'd0, if_valid}, 32'd1);
      check("stream_pc",    if_pc, exp_pc[i]);
      check("stream_inst",  if_inst, exp_inst[i]);
      check("stream_count", {30'd0, if_count}, 32'd1);
    end

    // Backpressure right after reset.
    reset = 1'b1; if_ready = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_count", {30'd0, if_count}, (i == 0) ? 32'd1 : 32'd2);
      check("bp_addr",  imem_addr, (i == 0) ? 32'h8 : 32'hC);
      check("bp_pc",    if_pc, 32'h4);
      check("bp_inst",  if_inst, 32'h0010_0293);
    end
    if_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      step();
      check("bp_rel_pc",    if_pc, exp_pc[j]);
      check("bp_rel_inst",  if_inst, exp_inst[j]);
      check("bp_rel_count", {30'd0, if_count}, 32'd2);
    end

    // Misaligned redirect on a full buffer with decode ready.
    redirect_valid = 1'b1; redirect_pc = 32'h1F;
    step();
    redirect_valid = 1'b0;
    check("rd_count", {30'd0, if_count}, 32'd0);
    check("rd_valid", {31'd0, if_valid}, 32'd0);
    check("rd_addr",  imem_addr, 32'h1C);
    step();
    check("rd_pc1",   if_pc, 32'h1C);
    check("rd_inst1", if_inst, 32'h0062_8263);
    step();
    check("rd_pc2",   if_pc, 32'h20);
    check("rd_inst2", if_inst, 32'h0062_82B3);

    // Redirect with a valid head and if_ready in the same cycle.
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    check("rdr_count", {30'd0, if_count}, 32'd0);
    step();
    check("rdr_pc",    if_pc, 32'h10);
    check("rdr_inst",  if_inst, 32'h0062_E3B3);
    check("rdr_count1", {30'd0, if_count}, 32'd1);

    // PC wrap past the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_pc0",   if_pc, 32'hFFFF_FFFC);
    check("wrap_inst0", if_inst, 32'h5A5A_FFFC);
    check("wrap_addr1", imem_addr, 32'h0);
    step();
    check("wrap_pc1",   if_pc, 32'h0);
    check("wrap_inst1", if_inst, 32'hA5A5_0000);

    // Asynchronous reset between edges on a full buffer.
    if_ready = 1'b0;
    step();
    check("ar_full", {30'd0, if_count}, 32'd2);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", {31'd0, if_valid}, 32'd0);
    check("ar_inst",  if_inst, 32'h0);
    check("ar_pc",    if_pc, 32'h0);
    check("ar_addr",  imem_addr, 32'h4);
    check("ar_count", {30'd0, if_count}, 32'd0);
    step();
    reset = 1'b0; if_ready = 1'b1;
    step();
    check("ar_pc1",   if_pc, 32'h4);
    check("ar_inst1", if_inst, 32'h0010_0293);
    step();
    check("ar_pc2",   if_pc, 32'h8);
    check("ar_inst2", if_inst, 32'h0030_0313);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
